// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM states,
// status-word bit positions and IO address select bits.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_e;

   localparam int OVF_BIT  = 10;
   localparam int FULL_BIT = 9;
   localparam int IDLE_BIT = 8;

   localparam int ADDR_DATA_BIT = 3;
   localparam int ADDR_CTRL_BIT = 4;

   // Counter/pointer widths must stay at least one bit for degenerate sizes.
   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART shifter; DEPTH=1 degenerates to a single
// holding register. A push while full is accepted only alongside a pop.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic       clk,
   input  logic       resetn,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic [7:0] count,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = clog2_min1(DEPTH);
   localparam int CNT_W = clog2_min1(DEPTH + 1);
   localparam int MEM_N = 1 << PTR_W;

   logic [7:0]       mem_q [MEM_N];
   logic [7:0]       mem_d [MEM_N];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;
   logic             accept;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign full   = (count_q == CNT_W'(DEPTH));
   assign empty  = (count_q == '0);
   assign do_pop = pop && !empty;
   assign accept = push && (!full || do_pop);
   assign rdata  = mem_q[rd_ptr_q];
   assign count  = 8'(count_q);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (accept && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!accept && do_pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with status word readback.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise one holding register.
module uart_tx_io
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 27000000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 4
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] IO_mem_addr,
   input  logic [31:0] IO_mem_wdata,
   input  logic        IO_mem_wr,
   output logic [31:0] IO_mem_rdata,
   output logic        uart_tx
);

   localparam int CPB    = CLK_FREQ_HZ / BAUD;
   localparam int BAUD_W = clog2_min1(CPB);

`ifdef UART_TX_FIFO_EN
   localparam int BUF_DEPTH = FIFO_DEPTH;
`else
   localparam int BUF_DEPTH = 1;
   logic [31:0] fifo_depth_unused;
   assign fifo_depth_unused = FIFO_DEPTH;
`endif

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              ovf_q, ovf_d;

   logic              wr_data;
   logic              wr_ctrl;
   logic              pop;
   logic              baud_end;
   logic              idle;
   logic [7:0]        fifo_data;
   logic [7:0]        fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              unused_ok;

   assign wr_data   = IO_mem_wr && IO_mem_addr[ADDR_DATA_BIT];
   assign wr_ctrl   = IO_mem_wr && IO_mem_addr[ADDR_CTRL_BIT] && IO_mem_wdata[0];
   assign baud_end  = (baud_q == BAUD_W'(CPB - 1));
   assign idle      = (state_q == ST_IDLE) && fifo_empty;
   assign uart_tx   = tx_q;
   assign unused_ok = ^{IO_mem_addr[31:5], IO_mem_addr[2:0], IO_mem_wdata[31:8]};

   uart_tx_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (wr_data),
      .pop    (pop),
      .wdata  (IO_mem_wdata[7:0]),
      .rdata  (fifo_data),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               tx_d    = 1'b0;
               baud_d  = '0;
               state_d = ST_START;
            end else begin
               tx_d = 1'b1;
            end
         end
         ST_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            // The shifter moves right each bit so the next bit is always shift_q[1].
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Setting wins over a clear issued in the same cycle so no drop goes unreported.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_ctrl) begin
         ovf_d = 1'b0;
      end
      if (wr_data && fifo_full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   always_comb begin
      IO_mem_rdata           = '0;
      IO_mem_rdata[7:0]      = fifo_count;
      IO_mem_rdata[IDLE_BIT] = idle;
      IO_mem_rdata[FULL_BIT] = fifo_full;
      IO_mem_rdata[OVF_BIT]  = ovf_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_io.sv
// Directed bench for uart_tx_io at CPB=10; frame timing and status words are
// hand-derived, with buffer-depth-dependent cases selected by UART_TX_FIFO_EN.
module tb_uart_tx_io;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [31:0] io_addr = '0;
   logic [31:0] io_wdata = '0;
   logic        io_wr = 1'b0;
   logic [31:0] io_rdata;
   logic        tx;

   int checks = 0;
   int errors = 0;

   uart_tx_io #(
      .CLK_FREQ_HZ (1000),
      .BAUD        (100),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .IO_mem_addr  (io_addr),
      .IO_mem_wdata (io_wdata),
      .IO_mem_wr    (io_wr),
      .IO_mem_rdata (io_rdata),
      .uart_tx      (tx)
   );

   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // One-cycle IO write; call #1 after a rising edge, returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata);
      io_addr  = addr;
      io_wdata = wdata;
      io_wr    = 1'b1;
      @(posedge clk);
      #1;
      io_wr    = 1'b0;
   endtask

   // Call at the falling edge 'lead' cycles after the start-bit edge.
   task automatic checkFrame(input logic [7:0] b, input int lead);
      checkOutput("start", {31'b0, tx}, 32'd0);
      repeat (15 - lead) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) repeat (10) @(negedge clk);
         checkOutput($sformatf("bit%0d_%h", i, b), {31'b0, tx}, {31'b0, b[i]});
      end
      repeat (10) @(negedge clk);
      checkOutput("stop", {31'b0, tx}, 32'd1);
   endtask

   // From mid-stop of one frame: one IDLE cycle, then the next frame.
   task automatic nextFrame(input logic [7:0] b);
      repeat (5) @(negedge clk);
      checkOutput("gap", {31'b0, tx}, 32'd1);
      @(negedge clk);
      checkFrame(b, 0);
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (io_rdata[8] !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, io_rdata, 32'h100);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #1 resetn = 1'b0;
      #2;
      checkOutput("reset_tx", {31'b0, tx}, 32'd1);
      checkOutput("reset_rdata", io_rdata, 32'h100);
      #20 resetn = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_rdata", io_rdata, 32'h100);

      // Single byte 0x55 with latency and idle-return timing.
      @(posedge clk);
      #1;
      applyStimulus(32'h8, 32'h55);
`ifdef UART_TX_FIFO_EN
      checkOutput("push_rdata", io_rdata, 32'h001);
`else
      checkOutput("push_rdata", io_rdata, 32'h201);
`endif
      @(negedge clk);
      checkOutput("latency_pre", {31'b0, tx}, 32'd1);
      @(negedge clk);
      checkOutput("popped_rdata", io_rdata, 32'h000);
      checkFrame(8'h55, 0);
      repeat (4) @(negedge clk);
      checkOutput("busy_before_idle", io_rdata, 32'h000);
      @(negedge clk);
      checkOutput("idle_after_frame", io_rdata, 32'h100);

`ifdef UART_TX_FIFO_EN
      // Back-to-back frames from a three-byte burst.
      @(posedge clk);
      #1;
      applyStimulus(32'h8, 32'h41);
      applyStimulus(32'h8, 32'h42);
      applyStimulus(32'h8, 32'h43);
      @(negedge clk);
      checkOutput("burst_count", io_rdata, 32'h002);
      checkFrame(8'h41, 1);
      nextFrame(8'h42);
      nextFrame(8'h43);
      repeat (5) @(negedge clk);
      checkOutput("burst_idle", io_rdata, 32'h100);

      // Six pushes into depth 4: one popped, four held, last dropped.
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) applyStimulus(32'h8, 32'h11 + i);
      checkOutput("ovf_set", io_rdata, 32'h604);
      applyStimulus(32'h10, 32'h1);
      checkOutput("ovf_clear", io_rdata, 32'h204);
      repeat (95) @(posedge clk);
      #1;
      applyStimulus(32'h8, 32'h77);
      checkOutput("push_full_with_pop", io_rdata, 32'h204);
      waitIdle("drain_idle");
`else
      // Holding register: 0x01 kept behind 0xAA, 0x02 dropped.
      @(posedge clk);
      #1;
      applyStimulus(32'h8, 32'hAA);
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(32'h8, 32'h01);
      applyStimulus(32'h8, 32'h02);
      checkOutput("ovf_set", io_rdata, 32'h601);
      applyStimulus(32'h10, 32'h1);
      checkOutput("ovf_clear", io_rdata, 32'h201);
      repeat (96) @(negedge clk);
      checkOutput("gap_a", {31'b0, tx}, 32'd1);
      @(negedge clk);
      checkFrame(8'h01, 0);

      // Push into the full register on the very edge it is popped.
      @(posedge clk);
      #1;
      applyStimulus(32'h8, 32'h03);
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(32'h8, 32'h04);
      checkOutput("push_full_with_pop", io_rdata, 32'h201);
      @(negedge clk);
      checkFrame(8'h03, 0);
      nextFrame(8'h04);
      repeat (5) @(negedge clk);
      checkOutput("hold_idle", io_rdata, 32'h100);
`endif

      // Asynchronous reset in the middle of a start bit.
      @(posedge clk);
      #1;
      applyStimulus(32'h8, 32'h00);
      repeat (3) @(negedge clk);
      checkOutput("pre_reset_tx", {31'b0, tx}, 32'd0);
      #2 resetn = 1'b0;
      #1;
      checkOutput("midframe_reset_tx", {31'b0, tx}, 32'd1);
      checkOutput("midframe_reset_rdata", io_rdata, 32'h100);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("recovered_rdata", io_rdata, 32'h100);
      @(posedge clk);
      #1;
      applyStimulus(32'h8, 32'h80);
      @(negedge clk);
      @(negedge clk);
      checkOutput("recovered_start", {31'b0, tx}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
